pm_seq: RTL and testbench

PM_SEQ -- requirements
Module: pm_seq

---
 rtl/pm_seq.sv | 142 ++++++++++++++
 tb/tb_pm_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pm_seq                                                       |
// | Description : Sequential shift-add multiplier with valid/ready handshakes. |
// |               IDLE accepts an operand pair, CALC runs WIDTH iterations     |
// |               (one per clock), DONE presents the product until consumed.   |
// |               Optional macro PM_SIGNED_EN: two's-complement operands and   |
// |               product (magnitude multiply plus final sign correction).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pm_seq #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] c
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] mcand;      // latched multiplicand (magnitude in signed mode)
  logic [WIDTH-1:0] mplier;     // latched multiplier (magnitude in signed mode)
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;        // current multiplier bit index, 0..WIDTH-1

  logic             accept;
  logic             last_iter;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [PW-1:0]    partial;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    result;

  assign accept    = (state == IDLE) && in_valid;
  assign last_iter = (state == CALC) && (cnt == CNT_LAST);

  // Shifted multiplicand contributes only when the current multiplier bit is set.
  assign partial = mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
  assign sum     = acc + partial;

`ifdef PM_SIGNED_EN
  logic neg;

  // The most-negative value negates to itself, which read unsigned is its true magnitude.
  assign a_mag  = a[WIDTH-1] ? -a : a;
  assign b_mag  = b[WIDTH-1] ? -b : b;
  assign result = neg ? -sum : sum;

  // Result sign is captured with the operands so later a/b changes cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= a[WIDTH-1] ^ b[WIDTH-1];
    end
  end
`else
  assign a_mag  = a;
  assign b_mag  = b;
  assign result = sum;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake decodes of the registered state.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, accumulate, and publish the product on the final iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      c      <= '0;
    end else if (accept) begin
      mcand  <= a_mag;
      mplier <= b_mag;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == CALC) begin
      acc <= sum;
      if (last_iter) begin
        c <= result;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pm_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_pm_seq                                                    |
// | Description : Self-checking bench for pm_seq (WIDTH=4) with a scoreboard   |
// |               of expected products. Honours PM_SIGNED_EN in its model.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_pm_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int t_prev   = 0;

  logic [2*W-1:0] exp_q[$];

  pm_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference product, computed at full integer precision then truncated.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint sx;
    longint sy;
    longint p;
`ifdef PM_SIGNED_EN
    sx = $signed(x);
    sy = $signed(y);
`else
    sx = longint'(x);
    sy = longint'(y);
`endif
    p = sx * sy;
    return p[2*W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Waits (bounded) for out_valid; scrambles a/b every cycle if in_valid is held.
  task automatic wait_valid();
    int n = 0;
    while (!out_valid && n < 64) begin
      check("calc_in_ready_low", in_ready, 1'b0);
      if (in_valid) begin
        a = W'($urandom);
        b = W'($urandom);
      end
      step();
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(cyc - t_acc), 64'(W));
  endtask

  task automatic pop_and_check(output logic [2*W-1:0] e);
    e = '0;
    check("sb_nonempty", exp_q.size() > 0, 1'b1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("product", c, e);
    end
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    int n = 0;
    while (!in_ready && n < 64) begin
      step();
      n++;
    end
    check("issue_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    a = x;
    b = y;
    step();
    t_prev = t_acc;
    t_acc  = cyc;
    exp_q.push_back(model(x, y));
    check("accept_ready_low", in_ready, 1'b0);
    if (!hold) begin
      in_valid = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
  endtask

  task automatic collect(input int bp);
    logic [2*W-1:0] e;
    wait_valid();
    pop_and_check(e);
    for (int i = 0; i < bp; i++) begin
      step();
      check("bp_valid", out_valid, 1'b1);
      check("bp_c", c, e);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("ret_out_valid", out_valid, 1'b0);
    check("ret_in_ready", in_ready, 1'b1);
    check("ret_hold_c", c, e);
  endtask

  logic [W-1:0] da[8] = '{4'd2, 4'd15, 4'd8, 4'd0, 4'd15, 4'd1, 4'd7, 4'd5};
  logic [W-1:0] db[8] = '{4'd3, 4'd15, 4'd8, 4'd9, 4'd1, 4'd15, 4'd9, 4'd10};
  int           dbp[8] = '{0, 5, 1, 0, 2, 0, 3, 1};

  initial begin
    logic [2*W-1:0] e;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3;
    check("rst_c", c, '0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // out_ready outside DONE has no effect.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("idle_oready_in_ready", in_ready, 1'b1);
    check("idle_oready_out_valid", out_valid, 1'b0);
    check("idle_oready_c", c, '0);
    out_ready = 1'b0;

    // Directed corners, including all-ones and most-negative operands.
    for (int i = 0; i < 8; i++) begin
      issue(da[i], db[i], 1'b0);
      collect(dbp[i]);
    end

    // Random pairs with random backpressure.
    for (int i = 0; i < 10; i++) begin
      issue(W'($urandom), W'($urandom), 1'b0);
      collect(int'($urandom_range(0, 3)));
    end

    // in_valid held with changing operands during CALC: first pair wins.
    issue(4'd6, 4'd11, 1'b1);
    collect(2);

    // Reset in the second CALC cycle of 7 x 9 aborts it.
    issue(4'd7, 4'd9, 1'b0);
    step();
    rst_n = 1'b0;
    #1;
    check("abort_c", c, '0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    step();
    issue(4'd3, 4'd5, 1'b0);
    collect(0);

    // Back-to-back with out_ready tied high.
    out_ready = 1'b1;
    issue(4'd2, 4'd3, 1'b0);
    wait_valid();
    pop_and_check(e);
    issue(4'd0, 4'd15, 1'b0);
    check("b2b_spacing", 64'(t_acc - t_prev), 64'(W + 2));
    wait_valid();
    pop_and_check(e);
    step();
    out_ready = 1'b0;
    check("b2b_idle", in_ready, 1'b1);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
